stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Parametrised hardware stack for the single-cycle RISC core; successor to the fixed push/pop SP control path.
- Holds PUSH/CALL/POP/RET data in on-chip storage with its own occupancy counter, overflow/underflow detection and a valid/ready request/response handshake.
- Drives the architectural stack pointer value written back to the register bank.
- Sits between the control unit (which supplies the stack operation) and the register file / PC-control (which consume pop/return data).

Parameters:
DATA_W, 32, width of each stack entry (register value or return PC)
DEPTH, 16, number of entries; any value >= 2
SP_TOP, 32'h0000_03FC, byte address reported by sp_out when the stack is empty
SP_STEP, 4, byte decrement of sp_out per occupied entry

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  stack operation request
req_ready  out  1  engine can accept a request this cycle
req_op  in  3  000 NOP, 001 PUSH, 010 CALL, 011 RET, 100 POP; others treated as NOP
req_data  in  DATA_W  PUSH operand (Rt value) or CALL return address (NPC)
rsp_valid  out  1  pop/return data available
rsp_ready  in  1  consumer takes response
rsp_data  out  DATA_W  popped value / RET target
rsp_err  out  1  response produced from an empty stack
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf  out  1  sticky overflow flag
unf  out  1  sticky underflow flag
clr_err  in  1  clears ovf/unf
sp_out  out  32  SP_TOP - count*SP_STEP, combinational from count

Behaviour:
- Reset (rst low, async):
  - state IDLE, count 0, rsp_valid 0, rsp_data 0, rsp_err 0, ovf 0, unf 0.
  - Storage contents not reset.
  - Reset asserted in READ or RESP aborts the operation; no response is issued after release.
- FSM states:
  - IDLE: req_ready=1.
  - READ: req_ready=0.
  - RESP: req_ready=0, rsp_valid=1.
- Accept: req_valid && req_ready at a rising edge.
- PUSH/CALL accepted, not full: mem[count] <= req_data; count <= count+1; stay IDLE. No response. Back-to-back pushes sustain one per cycle.
- PUSH/CALL accepted when full: no write; count unchanged; ovf <= 1; stay IDLE.
- POP/RET accepted, not empty:
  - Edge N: count <= count-1, read address count-1 latched, go READ.
  - Edge N+1: rsp_data <= mem[addr], rsp_err <= 0, go RESP.
  - rsp_valid is therefore high from after edge N+1 (2-cycle latency).
- POP/RET accepted when empty:
  - count stays 0; unf <= 1; go READ.
  - Edge N+1: rsp_data <= 0, rsp_err <= 1, go RESP.
- RESP: holds rsp_valid, rsp_data and rsp_err stable until rsp_ready is high at an edge, then returns to IDLE. The next request can be accepted the cycle after.
- NOP / undefined op accepted in IDLE: no state change.
- full, empty and sp_out follow count combinationally. sp_out uses 32-bit unsigned arithmetic; no wrap checking.
- clr_err clears ovf and unf. If a new error occurs at the same edge as clr_err, the set wins.
- rsp_data is not cleared on leaving RESP; it holds its last value.

Optional Feature:
- Macro: STACK_ENGINE_WATERMARK_EN.
- When defined:
  - Adds output hwm, width $clog2(DEPTH+1).
  - hwm is the maximum count reached since reset; it updates on the same edge as count and resets to 0.
  - clr_err also sets hwm <= count.
- When undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset, then PUSH 32'hA5A5_0001, 32'hA5A5_0002 back-to-back -> count=2, sp_out=32'h3F4, req_ready stays 1, no rsp_valid.
- POP after those pushes with rsp_ready held 0 for 3 cycles -> rsp_valid rises 2 cycles after accept, rsp_data=32'hA5A5_0002 stable until rsp_ready=1, then IDLE, count=1.
- DEPTH=16: 17 PUSHes -> full=1 after 16th, 17th sets ovf=1, count stays 16, entry 15 unchanged; pulse clr_err -> ovf=0.
- POP on empty stack -> unf=1, rsp_valid with rsp_data=0, rsp_err=1, count stays 0.
- CALL 32'h0000_0040 then RET -> rsp_data=32'h40, rsp_err=0; assert rst low during RET's READ state -> count=0, no rsp_valid after release.
- With STACK_ENGINE_WATERMARK_EN: push 5, pop 3 -> hwm=5, count=2; clr_err -> hwm=2.

Source files
------------

// File: rtl/stack_engine.sv
// stack_engine: parametrised hardware stack for the single-cycle RISC core.
// It stores PUSH/CALL operands in on-chip storage and returns POP/RET data
// over a valid/ready response channel with a fixed two-cycle latency.
// It also reports occupancy, full/empty, sticky overflow/underflow and the
// architectural stack pointer value.
// Optional build macro STACK_ENGINE_WATERMARK_EN adds the hwm output, a
// high-water mark of the occupancy.
module stack_engine #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] SP_TOP  = 32'h0000_03FC,
    parameter int unsigned SP_STEP = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_op,
    input  logic [DATA_W-1:0]            req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf,
    input  logic                         clr_err,
    output logic [31:0]                  sp_out
`ifdef STACK_ENGINE_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_CALL = 3'b010,
        OP_RET  = 3'b011,
        OP_POP  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Stack storage. It has no reset; the read is registered in the FSM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [AW-1:0]     rd_addr_q;
    logic              rd_err_q;

    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    logic              accept;
    logic              is_push;
    logic              is_pop;
    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              push_ovf;
    logic              pop_ok;
    logic              pop_unf;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     pop_addr;

    // A request is taken only while the engine is idle and ready.
    assign accept  = req_valid && req_ready_q;
    assign is_push = (req_op == OP_PUSH) || (req_op == OP_CALL);
    assign is_pop  = (req_op == OP_RET)  || (req_op == OP_POP);

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    assign push_ok  = accept && is_push && !full_w;
    assign push_ovf = accept && is_push &&  full_w;
    assign pop_ok   = accept && is_pop  && !empty_w;
    assign pop_unf  = accept && is_pop  &&  empty_w;

    // The top of stack lives at count-1 and the next free slot is at count.
    // Both are below DEPTH whenever they are used, so truncating to AW is safe.
    assign wr_addr  = AW'(count_q);
    assign pop_addr = AW'(count_q - 1'b1);

    // Next occupancy. A push and a pop are never accepted in the same cycle.
    always_comb begin
        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Sticky error flags. A new error at the same edge as clr_err takes priority.
    always_comb begin
        ovf_d = (ovf_q && !clr_err) || push_ovf;
        unf_d = (unf_q && !clr_err) || pop_unf;
    end

    // Storage write port: the accepted push lands in the next free slot.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_addr] <= req_data;
        end
    end

    // Occupancy and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Request/response FSM. A pop is IDLE -> READ (storage read) -> RESP (hold until taken).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop_ok || pop_unf) begin
                        state_q     <= S_READ;
                        req_ready_q <= 1'b0;
                        rd_addr_q   <= pop_addr;
                        rd_err_q    <= pop_unf;
                    end
                end
                S_READ: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= rd_err_q;
                    rsp_data_q  <= rd_err_q ? '0 : mem_q[rd_addr_q];
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef STACK_ENGINE_WATERMARK_EN
    logic [CW-1:0] hwm_q;
    logic [CW-1:0] hwm_d;

    // The watermark tracks the post-edge occupancy. clr_err re-arms it at the
    // occupancy after that edge, so it never reads below count.
    always_comb begin
        hwm_d = hwm_q;
        if (clr_err) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign sp_out    = SP_TOP - (32'(count_q) * 32'(SP_STEP));

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed steps followed by a random
// phase, compared against a queue-based reference model of the stack.
module tb_stack_engine;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [31:0]   req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
    logic          clr_err = 1'b0;
    logic [31:0]   sp_out;
`ifdef STACK_ENGINE_WATERMARK_EN
    logic [CW-1:0] hwm;
`endif

    stack_engine dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf),
        .clr_err   (clr_err),
        .sp_out    (sp_out)
`ifdef STACK_ENGINE_WATERMARK_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stack contents as a queue plus the sticky flags.
    logic [31:0] model_q[$];
    bit          ovf_m = 1'b0;
    bit          unf_m = 1'b0;
    int          hwm_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".full"},  64'(full),  64'(n == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".sp_out"}, 64'(sp_out), 64'(32'h0000_03FC - 32'(n) * 32'd4));
        chk({tag, ".ovf"}, 64'(ovf), 64'(ovf_m));
        chk({tag, ".unf"}, 64'(unf), 64'(unf_m));
`ifdef STACK_ENGINE_WATERMARK_EN
        chk({tag, ".hwm"}, 64'(hwm), 64'(hwm_m));
`endif
    endtask

    // Present one request for exactly one rising edge; return at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] d);
        chk("req_ready_before_issue", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_push(input logic [2:0] op, input logic [31:0] d);
        issue(op, d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else ovf_m = 1'b1;
        if (model_q.size() > hwm_m) hwm_m = model_q.size();
        chk("push.rsp_valid", 64'(rsp_valid), 64'd0);
        check_state("push");
    endtask

    task automatic do_pop(input logic [2:0] op, input int hold);
        logic [31:0] exp_d;
        logic        exp_err;
        exp_err = (model_q.size() == 0);
        if (exp_err) begin
            exp_d = '0;
            unf_m = 1'b1;
        end else begin
            exp_d = model_q.pop_back();
        end
        issue(op, $urandom);
        // READ: no response yet, busy, occupancy already updated.
        chk("pop.read.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("pop.read.req_ready", 64'(req_ready), 64'd0);
        check_state("pop.read");
        @(negedge clk);
        chk("pop.resp.rsp_valid", 64'(rsp_valid), 64'd1);
        chk("pop.resp.rsp_data",  64'(rsp_data),  64'(exp_d));
        chk("pop.resp.rsp_err",   64'(rsp_err),   64'(exp_err));
        chk("pop.resp.req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("pop.hold.rsp_valid", 64'(rsp_valid), 64'd1);
            chk("pop.hold.rsp_data",  64'(rsp_data),  64'(exp_d));
            chk("pop.hold.rsp_err",   64'(rsp_err),   64'(exp_err));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("pop.done.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("pop.done.req_ready", 64'(req_ready), 64'd1);
        chk("pop.done.rsp_data_held", 64'(rsp_data), 64'(exp_d));
        check_state("pop.done");
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        hwm_m = model_q.size();
        check_state("clr");
    endtask

    task automatic do_nop(input logic [2:0] op);
        issue(op, $urandom);
        chk("nop.rsp_valid", 64'(rsp_valid), 64'd0);
        check_state("nop");
    endtask

    task automatic reset_model();
        model_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        hwm_m = 0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] nop_ops[4];
        int r;
        nop_ops = '{3'd0, 3'd5, 3'd6, 3'd7};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_data",  64'(rsp_data),  64'd0);
        chk("reset.rsp_err",   64'(rsp_err),   64'd0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        reset_model();
        check_state("reset");
        rst = 1'b1;
        @(negedge clk);

        // Two back-to-back pushes.
        do_push(3'd1, 32'hA5A5_0001);
        do_push(3'd1, 32'hA5A5_0002);
        chk("b2b.sp_out", 64'(sp_out), 64'h3F4);
        $display("step: two pushes, count=%0d sp_out=%h", count, sp_out);

        // Pop with the consumer stalling for three cycles.
        do_pop(3'd4, 3);
        chk("pop1.count", 64'(count), 64'd1);
        do_pop(3'd4, 0);
        $display("step: pops done, count=%0d", count);

        // Fill to full, then overflow.
        for (int i = 0; i < 16; i++) do_push(3'd1, 32'hC0DE_0000 + 32'(i));
        chk("fill.full", 64'(full), 64'd1);
        do_push(3'd1, 32'hDEAD_BEEF);
        chk("ovf.set", 64'(ovf), 64'd1);
        chk("ovf.count", 64'(count), 64'd16);
        do_pop(3'd4, 1);
        do_clr();
        chk("ovf.cleared", 64'(ovf), 64'd0);
        $display("step: overflow exercised and cleared");

        // Drain the stack, then pop from empty.
        while (model_q.size() > 0) do_pop(3'd4, 0);
        do_pop(3'd4, 2);
        chk("unf.set", 64'(unf), 64'd1);
        chk("unf.count", 64'(count), 64'd0);
        do_clr();
        $display("step: underflow exercised and cleared");

        // CALL / RET round trip.
        do_push(3'd2, 32'h0000_0040);
        do_pop(3'd3, 0);
        $display("step: call/ret round trip");

        // Reset asserted while RET is in READ.
        do_push(3'd2, 32'h0000_0040);
        issue(3'd3, 32'h0);
        rst = 1'b0;
        #1;
        reset_model();
        chk("rst_read.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_read.req_ready", 64'(req_ready), 64'd1);
        check_state("rst_read");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_read.after.rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_read.after.req_ready", 64'(req_ready), 64'd1);
        end
        check_state("rst_read.after");
        $display("step: reset during READ aborted the response");

        // Watermark sequence: push 5, pop 3, clear.
        for (int i = 0; i < 5; i++) do_push(3'd1, 32'h1000 + 32'(i));
        for (int i = 0; i < 3; i++) do_pop(3'd4, 0);
        chk("wm.count", 64'(count), 64'd2);
        do_clr();
        $display("step: watermark sequence, count=%0d", count);

        // Random phase.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) do_push(3'($urandom_range(1, 2)), $urandom);
            else if (r <= 6) do_pop(r[0] ? 3'd3 : 3'd4, $urandom_range(0, 3));
            else if (r == 7) do_nop(nop_ops[$urandom_range(0, 3)]);
            else if (r == 8) do_clr();
            else begin
                @(negedge clk);
                check_state("idle");
            end
        end
        $display("step: random phase done, count=%0d ovf=%0d unf=%0d", count, ovf, unf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
